// File: rtl/esc_array.sv
// esc_array: N-channel servo-style ESC pulse generator with per-channel slew-limited speed.
// Latency: speed sampled at frame start (cnt==0); pulse rises on that same edge; all outputs registered.
// Backpressure: none; free-running frame counter, speed inputs are latched once per frame.
module esc_array #(
    parameter int NUM_MTR   = 4,
    parameter int SPD_W     = 11,
    parameter int PERIOD_W  = 18,
    parameter int MIN_PULSE = 50000,
    parameter int SHFT      = 4,
    parameter int SLEW      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_MTR*SPD_W-1:0] spd,
    input  logic                     motors_off,
    output logic [NUM_MTR-1:0]       pwm,
    output logic                     prd_strt,
    output logic                     ramping
);

    localparam longint MAX_PW  = longint'(MIN_PULSE) + (((longint'(1) << SPD_W) - 1) << SHFT);
    localparam longint CNT_MAX = (longint'(1) << PERIOD_W) - 1;

    localparam logic signed [SPD_W:0] SLEW_S = (SPD_W+1)'(SLEW);
    localparam logic [SPD_W-1:0]      SLEW_U = SPD_W'(SLEW);
    localparam logic [PERIOD_W-1:0]   MIN_PW = PERIOD_W'(MIN_PULSE);

    // The longest pulse must still leave at least one low cycle before the next frame.
    if (MAX_PW >= CNT_MAX) begin : g_width_chk
        $error("esc_array: longest pulse leaves no low gap in the frame");
    end

    logic [PERIOD_W-1:0]   cnt;
    logic [PERIOD_W-1:0]   cnt_nxt;
    logic                  frm_strt;
    logic                  any_diff;
    logic [SPD_W-1:0]      spd_ch  [NUM_MTR];
    logic [SPD_W-1:0]      tgt     [NUM_MTR];
    logic [SPD_W-1:0]      app     [NUM_MTR];
    logic [SPD_W-1:0]      app_nxt [NUM_MTR];
    logic signed [SPD_W:0] diff    [NUM_MTR];
    logic [PERIOD_W-1:0]   pw      [NUM_MTR];
    logic [PERIOD_W-1:0]   pw_nxt  [NUM_MTR];

    assign cnt_nxt  = cnt + PERIOD_W'(1);
    assign frm_strt = (cnt == '0);

    // Per channel: slew-limited step toward the sampled speed and the pulse width it implies
    always_comb begin
        any_diff = 1'b0;
        for (int i = 0; i < NUM_MTR; i++) begin
            spd_ch[i] = spd[i*SPD_W +: SPD_W];
            // One extra bit so the signed difference never wraps.
            diff[i]   = $signed({1'b0, spd_ch[i]}) - $signed({1'b0, app[i]});
            if (motors_off) begin
                app_nxt[i] = '0;
            end else if (diff[i] > SLEW_S) begin
                app_nxt[i] = app[i] + SLEW_U;
            end else if (diff[i] < -SLEW_S) begin
                app_nxt[i] = app[i] - SLEW_U;
            end else begin
                app_nxt[i] = spd_ch[i];
            end
            pw_nxt[i] = MIN_PW + (PERIOD_W'(app_nxt[i]) << SHFT);
            any_diff  = any_diff | (app[i] != tgt[i]);
        end
    end

    // Frame counter, frame-start strobe and ramp status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            prd_strt <= 1'b0;
            ramping  <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            prd_strt <= frm_strt;
            ramping  <= any_diff;
        end
    end

    // Per-channel target/applied speed, latched width and pulse output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_MTR; i++) begin
                tgt[i] <= '0;
                app[i] <= '0;
                pw[i]  <= MIN_PW;
            end
            pwm <= '0;
        end else begin
            for (int i = 0; i < NUM_MTR; i++) begin
                // motors_off clears speeds on every edge and overrides a coincident frame start.
                if (motors_off) begin
                    tgt[i] <= '0;
                    app[i] <= '0;
                end else if (frm_strt) begin
                    tgt[i] <= spd_ch[i];
                    app[i] <= app_nxt[i];
                end
                // Width only changes at frame start, so a pulse in progress keeps its latched width.
                if (frm_strt) begin
                    pw[i]  <= pw_nxt[i];
                    pwm[i] <= (pw_nxt[i] != '0);
                end else begin
                    pwm[i] <= (cnt_nxt != '0) && (cnt_nxt <= pw[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_esc_array.sv
// tb_esc_array: scoreboard bench for esc_array with a 4096-clock frame.
// Expected widths/ramp flags are queued from a small slew model at each frame start.
// A frame monitor measures each channel's high time and pops the queues to compare.
module tb_esc_array;

    localparam int NUM   = 4;
    localparam int SW    = 11;
    localparam int PW    = 12;
    localparam int MINP  = 1000;
    localparam int SH    = 0;
    localparam int SL    = 16;
    localparam int FRAME = 4096;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              motors_off = 1'b0;
    logic [NUM*SW-1:0] spd        = '0;
    logic [NUM-1:0]    pwm;
    logic              prd_strt;
    logic              ramping;

    int   vectors = 0;
    int   errors  = 0;
    int   exp_w [NUM][$];
    logic exp_r [$];
    int   mdl_app [NUM];
    bit   off_seen = 1'b0;
    int   last_w [NUM];

    esc_array #(
        .NUM_MTR(NUM), .SPD_W(SW), .PERIOD_W(PW),
        .MIN_PULSE(MINP), .SHFT(SH), .SLEW(SL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .spd(spd), .motors_off(motors_off),
        .pwm(pwm), .prd_strt(prd_strt), .ramping(ramping)
    );

    always #5 clk = ~clk;

    function automatic int spd_of(input int c);
        return int'(spd[c*SW +: SW]);
    endfunction

    task automatic set_spd(input int c, input int v);
        spd[c*SW +: SW] = SW'(v);
    endtask

    // Model the frame-start update and queue the widths/ramp flag it should produce.
    task automatic expect_frame();
        logic r;
        int   t;
        int   d;
        r = 1'b0;
        for (int c = 0; c < NUM; c++) begin
            t = motors_off ? 0 : spd_of(c);
            if (off_seen || motors_off) mdl_app[c] = 0;
            if (!motors_off) begin
                d = t - mdl_app[c];
                if (d > SL)       mdl_app[c] = mdl_app[c] + SL;
                else if (d < -SL) mdl_app[c] = mdl_app[c] - SL;
                else              mdl_app[c] = t;
            end
            exp_w[c].push_back(MINP + (mdl_app[c] << SH));
            if (mdl_app[c] != t) r = 1'b1;
        end
        exp_r.push_back(r);
        off_seen = motors_off;
    endtask

    // Measure one full frame from the prd_strt cycle; optionally drive new inputs at index ev_idx.
    task automatic run_frame(input int ev_idx, input logic [NUM*SW-1:0] ev_spd, input logic ev_off);
        int             guard;
        int             ns;
        int             cw [NUM];
        int             e;
        logic           r_s;
        logic           er;
        logic [NUM-1:0] fh;
        guard = 0;
        ns    = 0;
        r_s   = 1'b0;
        @(negedge clk);
        while (!prd_strt && guard < 2*FRAME) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (!prd_strt) begin
            errors++;
            $display("FAIL frame_start_timeout: prd_strt=%b required 1", prd_strt);
            return;
        end
        fh = pwm;
        for (int c = 0; c < NUM; c++) cw[c] = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk);
            for (int c = 0; c < NUM; c++) if (pwm[c]) cw[c]++;
            if (prd_strt) ns++;
            if (k == 100) r_s = ramping;
            if (k == ev_idx) begin
                spd        = ev_spd;
                motors_off = ev_off;
                if (ev_off) off_seen = 1'b1;
            end
        end
        for (int c = 0; c < NUM; c++) begin
            last_w[c] = cw[c];
            vectors++;
            if (exp_w[c].size() == 0) begin
                errors++;
                $display("FAIL width_ch%0d: measured %0d, no expectation queued", c, cw[c]);
            end else begin
                e = exp_w[c].pop_front();
                if (cw[c] !== e) begin
                    errors++;
                    $display("FAIL width_ch%0d: measured %0d required %0d", c, cw[c], e);
                end
            end
        end
        vectors++;
        if (fh !== {NUM{1'b1}}) begin
            errors++;
            $display("FAIL pulse_start: pwm at cnt=1 is %b required %b", fh, {NUM{1'b1}});
        end
        vectors++;
        if (ns !== 1) begin
            errors++;
            $display("FAIL prd_strt_count: %0d strobes per frame required 1", ns);
        end
        vectors++;
        if (exp_r.size() == 0) begin
            errors++;
            $display("FAIL ramping: measured %b, no expectation queued", r_s);
        end else begin
            er = exp_r.pop_front();
            if (r_s !== er) begin
                errors++;
                $display("FAIL ramping: measured %b required %b", r_s, er);
            end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        spd        = '0;
        motors_off = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (pwm !== '0) begin errors++; $display("FAIL reset_pwm: %b required 0", pwm); end
        vectors++;
        if (prd_strt !== 1'b0) begin errors++; $display("FAIL reset_prd_strt: %b required 0", prd_strt); end
        vectors++;
        if (ramping !== 1'b0) begin errors++; $display("FAIL reset_ramping: %b required 0", ramping); end
        rst_n = 1'b1;
        for (int c = 0; c < NUM; c++) mdl_app[c] = 0;
        off_seen = 1'b0;
        expect_frame();
        run_frame(-1, spd, 1'b0);
    endtask

    task automatic test_soft_start();
        int tbl [7] = '{1016, 1032, 1048, 1064, 1080, 1096, 1100};
        set_spd(0, 100);
        set_spd(1, 100);
        for (int k = 0; k < 7; k++) begin
            expect_frame();
            run_frame(-1, spd, 1'b0);
            vectors++;
            if (last_w[0] !== tbl[k]) begin
                errors++;
                $display("FAIL soft_start_f%0d: ch0 width %0d required %0d", k, last_w[0], tbl[k]);
            end
        end
    endtask

    task automatic test_mid_frame_change();
        logic [NUM*SW-1:0] nsp;
        nsp = spd;
        nsp[1*SW +: SW] = '0;
        nsp[2*SW +: SW] = 11'd2047;
        expect_frame();
        run_frame(1999, nsp, 1'b0);
        vectors++;
        if (last_w[2] !== 1000) begin
            errors++;
            $display("FAIL late_change_current: ch2 width %0d required 1000", last_w[2]);
        end
        expect_frame();
        run_frame(-1, spd, 1'b0);
        vectors++;
        if (last_w[2] !== 1016) begin
            errors++;
            $display("FAIL late_change_next: ch2 width %0d required 1016", last_w[2]);
        end
        vectors++;
        if (last_w[1] !== 1084) begin
            errors++;
            $display("FAIL soft_stop_f0: ch1 width %0d required 1084", last_w[1]);
        end
    endtask

    task automatic test_soft_stop();
        int tbl [6] = '{1068, 1052, 1036, 1020, 1004, 1000};
        for (int k = 0; k < 6; k++) begin
            expect_frame();
            run_frame(-1, spd, 1'b0);
            vectors++;
            if (last_w[1] !== tbl[k]) begin
                errors++;
                $display("FAIL soft_stop_f%0d: ch1 width %0d required %0d", k + 1, last_w[1], tbl[k]);
            end
        end
    endtask

    task automatic test_motors_off();
        expect_frame();
        run_frame(199, spd, 1'b1);
        vectors++;
        if (last_w[0] !== 1100) begin
            errors++;
            $display("FAIL off_inflight: ch0 width %0d required 1100", last_w[0]);
        end
        expect_frame();
        run_frame(-1, spd, 1'b1);
        vectors++;
        if (last_w[0] !== 1000) begin
            errors++;
            $display("FAIL off_idle: ch0 width %0d required 1000", last_w[0]);
        end
        motors_off = 1'b0;
        expect_frame();
        run_frame(-1, spd, 1'b0);
        vectors++;
        if (last_w[0] !== 1016) begin
            errors++;
            $display("FAIL off_release: ch0 width %0d required 1016", last_w[0]);
        end
    endtask

    task automatic test_async_reset();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!prd_strt && guard < 2*FRAME) begin
            @(negedge clk);
            guard++;
        end
        repeat (499) @(negedge clk);
        vectors++;
        if (pwm !== {NUM{1'b1}}) begin
            errors++;
            $display("FAIL pre_reset_pwm: %b required %b", pwm, {NUM{1'b1}});
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (pwm !== '0) begin errors++; $display("FAIL async_pwm: %b required 0", pwm); end
        vectors++;
        if (prd_strt !== 1'b0) begin errors++; $display("FAIL async_prd_strt: %b required 0", prd_strt); end
        vectors++;
        if (ramping !== 1'b0) begin errors++; $display("FAIL async_ramping: %b required 0", ramping); end
        spd        = '0;
        motors_off = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < NUM; c++) mdl_app[c] = 0;
        off_seen = 1'b0;
        expect_frame();
        run_frame(-1, spd, 1'b0);
    endtask

    initial begin
        test_reset();
        test_soft_start();
        test_mid_frame_change();
        test_soft_stop();
        test_motors_off();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
